uart_rx_fifo: RTL and testbench

Synthesizable, parametrised UART receiver with a receive FIFO, for the SoC peripheral bus. It replaces the testbench-only 8N1 serial monitor with a hardware block. Data width, parity mode, stop-bit count and FIFO depth are configurable. The block reports framing, parity and overrun errors, and software drains bytes through a valid/ready read port.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 59 +++++
 rtl/uart_rx_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t     receiver FSM state encoding (legacy localparam constants)
//   PARITY_*       parity mode selectors for the PARITY parameter
//   cnt_width()    bit width of a counter that spans 0..n-1
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t RX_IDLE   = 3'd0;
    localparam rx_state_t RX_START  = 3'd1;
    localparam rx_state_t RX_DATA   = 3'd2;
    localparam rx_state_t RX_PARITY = 3'd3;
    localparam rx_state_t RX_STOP   = 3'd4;
    localparam rx_state_t RX_BREAK  = 3'd5;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Circular-buffer FIFO with first-word fall-through read data.
//   clk, reset  clock, asynchronous active-high reset
//   push, din   write request and data (dropped when full unless popped)
//   pop         read request (ignored when empty)
//   dout        head entry, 0 while empty
//   full, empty occupancy status
//   level       number of stored entries
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Gate with empty so the read port shows 0 after reset rather than stale storage.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (configurable data bits, parity, stop bits) feeding a receive
// FIFO drained through a valid/ready port.
//   clk, reset      system clock, asynchronous active-high reset
//   rx_i            serial line, asynchronous, idle high
//   rd_data_o       FIFO head entry
//   rd_valid_o      FIFO non-empty
//   rd_ready_i      pop the head entry when rd_valid_o is high
//   level_o         FIFO occupancy
//   frame_err_o     sticky, a stop bit was sampled low
//   parity_err_o    sticky, parity mismatch
//   overrun_o       sticky, a byte arrived while the FIFO was full
//   clear_err_i     clears all sticky flags (a same-cycle new error wins)
//   busy_o          receiver not idle
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 40000000,
    parameter int unsigned BAUDRATE   = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          rd_data_o,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o,
    input  logic                          clear_err_i,
    output logic                          busy_o
);

    localparam int unsigned   DIV           = CLK_FREQ / BAUDRATE;
    localparam int unsigned   CW            = cnt_width(DIV);
    // Start bit is checked half a bit time after the falling edge.
    localparam logic [CW-1:0] START_PRELOAD = CW'(DIV - 1 - DIV / 2);
    localparam logic [CW-1:0] CNT_LAST      = CW'(DIV - 1);
    localparam logic          ODD_INV       = (PARITY == PARITY_ODD);

    // Internal reset: asserts asynchronously, releases two clocks after reset drops.
    logic [1:0] rst_sync;
    logic       rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    logic rx_meta, rx_s, rx_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_bad_q, par_bad_d;
    logic          stop_bad_q, stop_bad_d;
    logic          tick, push, set_perr, set_ferr, set_ovr;
    logic          fifo_full, fifo_empty;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        push       = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d    = RX_DATA;
                        idx_d      = 3'd0;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d    = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    if (rx_s != ((^shreg_q[DATA_BITS-1:0]) ^ ODD_INV)) begin
                        set_perr  = 1'b1;
                        par_bad_d = 1'b1;
                    end
                    state_d    = RX_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    set_ferr = ~rx_s;
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        if (!rx_s || stop_bad_q) begin
                            state_d = RX_BREAK;
                        end else begin
                            push    = ~par_bad_q;
                            state_d = RX_IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                        stop_bad_d = stop_bad_q | ~rx_s;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Bit timer restarts on every state change; free-runs while staying in a state.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = (state_d == RX_START) ? START_PRELOAD : '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    assign rd_valid_o = ~fifo_empty;
    assign set_ovr    = push & fifo_full & ~(rd_ready_i & rd_valid_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            frame_err_o  <= (frame_err_o  & ~clear_err_i) | set_ferr;
            parity_err_o <= (parity_err_o & ~clear_err_i) | set_perr;
            overrun_o    <= (overrun_o    & ~clear_err_i) | set_ovr;
        end
    end

    assign busy_o = (state_q != RX_IDLE);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (rst),
        .push  (push),
        .din   (shreg_q[DATA_BITS-1:0]),
        .pop   (rd_ready_i),
        .dout  (rd_data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Three receivers side by side: 8N1/depth 16, 8E1/depth 4, 7E2/depth 4.
// Bytes expected in a FIFO are queued per receiver when sent and compared
// in order when drained.
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ = 40000000;
    localparam int unsigned BAUDRATE = 1000000;
    localparam int          DIV      = 40;

    logic       clk;
    logic       reset;
    logic [2:0] rx;
    logic [2:0] rdy;
    logic [2:0] clr;
    logic [2:0] valid, ferr, perr, ovr, busy;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic [4:0] level0;
    logic [2:0] level1, level2;

    int n_checks = 0;
    int n_errors = 0;

    int nb_cfg  [3] = '{8, 8, 7};
    int par_cfg [3] = '{0, 2, 2};
    int stp_cfg [3] = '{1, 1, 2};

    logic [7:0] exp_q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ), .BAUDRATE (BAUDRATE), .DATA_BITS (8),
        .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (16)
    ) u_n81 (
        .clk (clk), .reset (reset), .rx_i (rx[0]), .rd_data_o (d0),
        .rd_valid_o (valid[0]), .rd_ready_i (rdy[0]), .level_o (level0),
        .frame_err_o (ferr[0]), .parity_err_o (perr[0]), .overrun_o (ovr[0]),
        .clear_err_i (clr[0]), .busy_o (busy[0])
    );

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ), .BAUDRATE (BAUDRATE), .DATA_BITS (8),
        .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) u_e81 (
        .clk (clk), .reset (reset), .rx_i (rx[1]), .rd_data_o (d1),
        .rd_valid_o (valid[1]), .rd_ready_i (rdy[1]), .level_o (level1),
        .frame_err_o (ferr[1]), .parity_err_o (perr[1]), .overrun_o (ovr[1]),
        .clear_err_i (clr[1]), .busy_o (busy[1])
    );

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ), .BAUDRATE (BAUDRATE), .DATA_BITS (7),
        .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (4)
    ) u_e72 (
        .clk (clk), .reset (reset), .rx_i (rx[2]), .rd_data_o (d2),
        .rd_valid_o (valid[2]), .rd_ready_i (rdy[2]), .level_o (level2),
        .frame_err_o (ferr[2]), .parity_err_o (perr[2]), .overrun_o (ovr[2]),
        .clear_err_i (clr[2]), .busy_o (busy[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_data(input int inst);
        case (inst)
            0:       return d0;
            1:       return d1;
            default: return {1'b0, d2};
        endcase
    endfunction

    function automatic int get_level(input int inst);
        case (inst)
            0:       return int'(level0);
            1:       return int'(level1);
            default: return int'(level2);
        endcase
    endfunction

    task automatic send_bit(input int inst, input logic b);
        rx[inst] = b;
        repeat (DIV) @(negedge clk);
    endtask

    // Parity is computed here from the payload; flip_par forces a wrong parity bit.
    task automatic send_frame(input int inst, input logic [7:0] data, input logic flip_par,
                              input logic [1:0] stop_val);
        logic p;
        send_bit(inst, 1'b0);
        p = 1'b0;
        for (int i = 0; i < nb_cfg[inst]; i++) begin
            send_bit(inst, data[i]);
            p = p ^ data[i];
        end
        if (par_cfg[inst] != 0) begin
            if (par_cfg[inst] == 1) p = ~p;
            send_bit(inst, p ^ flip_par);
        end
        for (int i = 0; i < stp_cfg[inst]; i++) send_bit(inst, stop_val[i]);
    endtask

    task automatic send_good(input int inst, input logic [7:0] data);
        exp_q[inst].push_back(data);
        send_frame(inst, data, 1'b0, 2'b11);
    endtask

    task automatic drain(input int inst);
        int n;
        logic [7:0] e;
        n = exp_q[inst].size();
        for (int i = 0; i < n; i++) begin
            e = exp_q[inst].pop_front();
            check_eq($sformatf("valid%0d[%0d]", inst, i), valid[inst], 1);
            check_eq($sformatf("data%0d[%0d]", inst, i), get_data(inst), e);
            rdy[inst] = 1'b1;
            @(negedge clk);
            rdy[inst] = 1'b0;
        end
        check_eq($sformatf("drained_valid%0d", inst), valid[inst], 0);
        check_eq($sformatf("drained_level%0d", inst), get_level(inst), 0);
    endtask

    task automatic clear_pulse(input int inst);
        clr[inst] = 1'b1;
        @(negedge clk);
        clr[inst] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    logic [7:0] hello [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    initial begin
        rx    = 3'b111;
        rdy   = 3'b000;
        clr   = 3'b000;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_valid%0d", i), valid[i], 0);
            check_eq($sformatf("rst_level%0d", i), get_level(i), 0);
            check_eq($sformatf("rst_data%0d", i), get_data(i), 0);
            check_eq($sformatf("rst_flags%0d", i), {busy[i], ferr[i], perr[i], ovr[i]}, 0);
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);

        // Basic 8N1 receive, no draining until all five bytes are in.
        for (int i = 0; i < 5; i++) send_good(0, hello[i]);
        check_eq("hello_level", level0, 5);
        check_eq("hello_flags", {ferr[0], perr[0], ovr[0]}, 0);
        drain(0);

        // Low stop bit followed by a long break.
        send_frame(0, 8'hA5, 1'b0, 2'b00);
        repeat (29 * DIV) @(negedge clk);
        check_eq("break_busy", busy[0], 1);
        check_eq("break_ferr", ferr[0], 1);
        check_eq("break_level", level0, 0);
        rx[0] = 1'b1;
        repeat (DIV) @(negedge clk);
        check_eq("break_release_busy", busy[0], 0);
        send_good(0, 8'h3C);
        drain(0);
        check_eq("ferr_sticky", ferr[0], 1);
        clear_pulse(0);
        check_eq("ferr_cleared", ferr[0], 0);

        // Even parity: good frame then bad parity bit.
        send_good(1, 8'h55);
        send_frame(1, 8'h55, 1'b1, 2'b11);
        check_eq("par_err", perr[1], 1);
        check_eq("par_level", level1, 1);
        check_eq("par_ferr", ferr[1], 0);
        drain(1);
        clear_pulse(1);
        check_eq("par_cleared", perr[1], 0);

        // Overrun on a depth-4 FIFO.
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) send_good(1, 8'(i));
            else        send_frame(1, 8'(i), 1'b0, 2'b11);
        end
        check_eq("ovr_level", level1, 4);
        check_eq("ovr_flag", ovr[1], 1);
        drain(1);
        clear_pulse(1);
        check_eq("ovr_cleared", ovr[1], 0);

        // Same again, but pop exactly on the cycle of the fifth push.
        // An 11-bit frame pushes on the posedge 423 clocks after its start bit.
        for (int i = 1; i <= 4; i++) send_frame(1, 8'(i), 1'b0, 2'b11);
        for (int i = 2; i <= 5; i++) exp_q[1].push_back(8'(i));
        fork
            send_frame(1, 8'h05, 1'b0, 2'b11);
            begin
                repeat (423) @(negedge clk);
                rdy[1] = 1'b1;
                @(negedge clk);
                rdy[1] = 1'b0;
            end
        join
        check_eq("popsame_ovr", ovr[1], 0);
        check_eq("popsame_level", level1, 4);
        drain(1);

        // 7E2: good frame, then second stop bit low.
        send_good(2, 8'h41);
        check_eq("e72_level", level2, 1);
        drain(2);
        send_frame(2, 8'h41, 1'b0, 2'b01);
        check_eq("e72_ferr", ferr[2], 1);
        check_eq("e72_perr", perr[2], 0);
        check_eq("e72_level_bad", level2, 0);
        rx[2] = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check_eq("e72_idle", busy[2], 0);

        // Short glitch: start bit rejected at its midpoint.
        rx[0] = 1'b0;
        repeat (10) @(negedge clk);
        rx[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("glitch_busy", busy[0], 1);
        repeat (2 * DIV) @(negedge clk);
        check_eq("glitch_idle", busy[0], 0);
        check_eq("glitch_level", level0, 0);
        check_eq("glitch_ferr", ferr[0], 0);

        // Reset in the middle of a frame with a byte already stored.
        send_frame(0, 8'h11, 1'b0, 2'b11);
        check_eq("prerst_level", level0, 1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        check_eq("prerst_busy", busy[0], 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_valid", valid[0], 0);
        check_eq("midrst_level", level0, 0);
        check_eq("midrst_data", d0, 0);
        check_eq("midrst_busy", busy[0], 0);
        check_eq("midrst_ferr2", ferr[2], 0);
        rx[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        send_good(0, 8'h7E);
        check_eq("postrst_level", level0, 1);
        drain(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
